// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_unit
// Function : Iterative radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_exceptionM,
  input  logic             pipe_stall,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             div_stall,
  output logic             div_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_valid;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_neg_a = div_signed & src_a[WIDTH-1];
  assign w_neg_b = div_signed & src_b[WIDTH-1];
  assign w_abs_a = w_neg_a ? -src_a : src_a;
  assign w_abs_b = w_neg_b ? -src_b : src_b;

  // The quotient bits are shifted into the low end of the dividend register.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_valid     <= 1'b0;
    end else if (flush_exceptionM) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_en) begin
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!div_en) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_q_next;
            r_cnt <= r_cnt + c_cnt_one;
            // Final iteration: sign-correct straight from the last step.
            if (r_cnt == c_last_iter) begin
              r_quotient  <= r_sign_q ? -w_q_next : w_q_next;
              r_remainder <= r_sign_r ? -w_rem_next : w_rem_next;
              r_valid     <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!pipe_stall) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_stall = div_en & (r_state != S_DONE) & ~flush_exceptionM;
  assign div_valid = r_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_unit
// Function : Directed self-checking bench for div_iter_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

  logic        clk;
  logic        rst;
  logic        flush_exceptionM;
  logic        pipe_stall;
  logic        div_en;
  logic        div_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        div_stall;
  logic        div_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks;
  int failures;

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_exceptionM (flush_exceptionM),
    .pipe_stall       (pipe_stall),
    .div_en           (div_en),
    .div_signed       (div_signed),
    .src_a            (src_a),
    .src_b            (src_b),
    .div_stall        (div_stall),
    .div_valid        (div_valid),
    .quotient         (quotient),
    .remainder        (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a divide, count stall cycles, check the result for hold+1 DONE cycles.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int hold,
                         input bit busy_stall, input bit check_zero);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rst        = 1'b0;
    div_en     = 1'b1;
    div_signed = sgn;
    src_a      = a;
    src_b      = b;
    #1;
    if (check_zero) begin
      check({tag, " rst_valid"}, {31'd0, div_valid}, 32'd0);
      check({tag, " rst_q"}, quotient, 32'd0);
      check({tag, " rst_r"}, remainder, 32'd0);
    end
    pipe_stall = busy_stall;
    while (div_stall === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, cnt, 32'd33);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      pipe_stall = (i < hold);
      check({tag, " valid"}, {31'd0, div_valid}, 32'd1);
      check({tag, " q"}, quotient, exp_q);
      check({tag, " r"}, remainder, exp_r);
    end
    div_en     = 1'b0;
    pipe_stall = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " valid_after"}, {31'd0, div_valid}, 32'd0);
    check({tag, " stall_after"}, {31'd0, div_stall}, 32'd0);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    flush_exceptionM = 1'b0;
    pipe_stall       = 1'b0;
    div_en           = 1'b0;
    div_signed       = 1'b0;
    src_a            = '0;
    src_b            = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset valid", {31'd0, div_valid}, 32'd0);
    check("reset stall", {31'd0, div_stall}, 32'd0);
    check("reset q", quotient, 32'd0);
    check("reset r", remainder, 32'd0);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1'b0, 1'b0);
    run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 1'b0, 1'b0);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 0, 1'b1, 1'b0);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 1'b0, 1'b0);
    run_div("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 1'b0, 1'b0);
    run_div("divu_7_0", 1'b0, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 0, 1'b0, 1'b0);
    run_div("div_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, 32'd1, 32'hFFFFFFF9, 0, 1'b0, 1'b0);
    run_div("divu_hold", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 5, 1'b0, 1'b0);

    // Flush at BUSY cycle 10; the previous result must be retained.
    @(negedge clk);
    div_en     = 1'b1;
    div_signed = 1'b0;
    src_a      = 32'd1000;
    src_b      = 32'd3;
    repeat (10) @(negedge clk);
    flush_exceptionM = 1'b1;
    #1;
    check("flush stall", {31'd0, div_stall}, 32'd0);
    check("flush valid", {31'd0, div_valid}, 32'd0);
    @(negedge clk);
    flush_exceptionM = 1'b0;
    div_en           = 1'b0;
    #1;
    check("flush valid_next", {31'd0, div_valid}, 32'd0);
    check("flush q_kept", quotient, 32'h0FFFFFFF);
    check("flush r_kept", remainder, 32'hF);
    @(negedge clk);
    #1;
    check("flush valid_idle", {31'd0, div_valid}, 32'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1'b0, 1'b0);

    // Reset in mid-BUSY, div_en held high, then a clean restart.
    @(negedge clk);
    div_en     = 1'b1;
    div_signed = 1'b0;
    src_a      = 32'd50;
    src_b      = 32'd5;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    run_div("divu_rst", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
